// File: rtl/oh_aoi_pipe.sv
// Pipelined N-bit 2-1-1 And-Or-Invert datapath, selectable per beat, with valid/ready stages and a transfer counter.
// Latency DEPTH cycles; in_ready collapses through full stages. OH_AOI_PIPE_PARITY_EN adds a per-beat parity bit.
module oh_aoi_pipe #(
    parameter int    N     = 8,
    parameter int    DEPTH = 2,
    parameter string PROP  = "DEFAULT"
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic [1:0]   mode,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] b0,
    input  logic [N-1:0] c0,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] z,
    output logic         out_parity,
    output logic [15:0]  out_count
);

    logic [N-1:0]     func;
    logic [DEPTH-1:0] valid_q;
    logic [N-1:0]     data_q [DEPTH];
    logic [DEPTH-1:0] ready;
    logic             all_full;

    // Non-default properties get the shared-term form so a cell mapper can bind compound gates directly.
    if (PROP == "DEFAULT") begin : g_func_infer
        always_comb begin
            func = '0;
            case (mode)
                2'b00:   func = ~((a0 & a1) | b0 | c0);
                2'b01:   func = ~((a0 | a1) & b0 & c0);
                2'b10:   func = (a0 & a1) | b0 | c0;
                default: func = (a0 | a1) & b0 & c0;
            endcase
        end
    end else begin : g_func_cell
        logic [N-1:0] and_or;
        assign and_or = mode[0] ? ((a0 | a1) & b0 & c0) : ((a0 & a1) | b0 | c0);
        assign func   = mode[1] ? and_or : ~and_or;
    end

    // ready_k = ~valid_k | ready_(k+1), unrolled as "out_ready or some stage at/after k is empty".
    always_comb begin
        all_full = 1'b1;
        ready    = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            all_full = all_full & valid_q[k];
            ready[k] = out_ready | ~all_full;
        end
    end

    assign in_ready  = ready[0] & nreset;
    assign out_valid = valid_q[DEPTH-1];
    assign z         = data_q[DEPTH-1];

`ifdef OH_AOI_PIPE_PARITY_EN
    logic [DEPTH-1:0] par_q;
    assign out_parity = par_q[DEPTH-1];
`else
    assign out_parity = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!nreset) begin
            valid_q   <= '0;
            out_count <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
`ifdef OH_AOI_PIPE_PARITY_EN
            par_q <= '0;
`endif
        end else begin
            // Data only moves with a valid beat so z keeps the last beat while the pipe drains.
            if (ready[0]) begin
                valid_q[0] <= in_valid;
                if (in_valid) begin
                    data_q[0] <= func;
`ifdef OH_AOI_PIPE_PARITY_EN
                    par_q[0] <= ^func;
`endif
                end
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (ready[k]) begin
                    valid_q[k] <= valid_q[k-1];
                    if (valid_q[k-1]) begin
                        data_q[k] <= data_q[k-1];
`ifdef OH_AOI_PIPE_PARITY_EN
                        par_q[k] <= par_q[k-1];
`endif
                    end
                end
            end
            if (out_valid && out_ready) begin
                out_count <= out_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_oh_aoi_pipe.sv
// Directed bench for oh_aoi_pipe (N=8, DEPTH=2): reset, latency, modes, back-to-back, backpressure, mid-stream reset, counter wrap.
module tb_oh_aoi_pipe;

`ifdef OH_AOI_PIPE_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nreset;
    logic [1:0]  mode;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a0, a1, b0, c0;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  z;
    logic        out_parity;
    logic [15:0] out_count;

    int tests_run    = 0;
    int tests_failed = 0;

    // mode table: spec vectors for all four modes plus a parity-1 result
    logic [1:0] vm [5];
    logic [7:0] va0 [5], va1 [5], vb0 [5], vc0 [5], ve [5];

    always #5 clk = ~clk;

    oh_aoi_pipe #(.N(8), .DEPTH(2), .PROP("DEFAULT")) dut (
        .clk(clk), .nreset(nreset), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .a0(a0), .a1(a1), .b0(b0), .c0(c0), .out_valid(out_valid), .out_ready(out_ready),
        .z(z), .out_parity(out_parity), .out_count(out_count)
    );

    task automatic set_vec(input int i, input logic [1:0] m, input logic [7:0] x0, input logic [7:0] x1,
                           input logic [7:0] y0, input logic [7:0] w0, input logic [7:0] e);
        vm[i] = m; va0[i] = x0; va1[i] = x1; vb0[i] = y0; vc0[i] = w0; ve[i] = e;
    endtask

    task automatic drive_vec(input int i);
        mode = vm[i]; a0 = va0[i]; a1 = va1[i]; b0 = vb0[i]; c0 = vc0[i];
    endtask

    // One clock: settle, sample handshakes before the edge, then move to just past the edge.
    task automatic cycle(output bit acc, output bit xfer, output logic [7:0] zs);
        #1;
        acc  = in_valid && in_ready;
        xfer = out_valid && out_ready;
        zs   = z;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nreset = 1'b0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b1;
    endtask

    task automatic test_reset();
        nreset = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        mode = 2'b00; a0 = 8'hF0; a1 = 8'hCC; b0 = 8'h01; c0 = 8'h02;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests_run++;
        if (z !== 8'h00) begin tests_failed++; $display("FAIL reset_z got %h want 00", z); end
        tests_run++;
        if (out_count !== 16'h0000) begin tests_failed++; $display("FAIL reset_count got %h want 0000", out_count); end
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        tests_run++;
        if (out_parity !== 1'b0) begin tests_failed++; $display("FAIL reset_parity got %b want 0", out_parity); end
        nreset = 1'b1; in_valid = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL release_in_ready got %b want 1", in_ready); end
        @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL release_out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_latency();
        mode = 2'b00; a0 = 8'hF0; a1 = 8'hCC; b0 = 8'h01; c0 = 8'h02;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL lat_early got %b want 0", out_valid); end
        @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL lat_valid got %b want 1", out_valid); end
        tests_run++;
        if (z !== 8'h3C) begin tests_failed++; $display("FAIL lat_z got %h want 3c", z); end
        tests_run++;
        if (out_parity !== 1'b0) begin tests_failed++; $display("FAIL lat_parity got %b want 0", out_parity); end
        @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL lat_one_cycle got %b want 0", out_valid); end
        tests_run++;
        if (out_count !== 16'd1) begin tests_failed++; $display("FAIL lat_count got %0d want 1", out_count); end
    endtask

    task automatic test_modes();
        bit found;
        set_vec(0, 2'b00, 8'hF0, 8'hCC, 8'h01, 8'h02, 8'h3C);
        set_vec(1, 2'b10, 8'hF0, 8'hCC, 8'h01, 8'h02, 8'hC3);
        set_vec(2, 2'b01, 8'hF0, 8'h0F, 8'hFF, 8'h3C, 8'hC3);
        set_vec(3, 2'b11, 8'hF0, 8'h0F, 8'hFF, 8'h3C, 8'h3C);
        set_vec(4, 2'b10, 8'h00, 8'h00, 8'hC7, 8'h00, 8'hC7);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_vec(i);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            found = 1'b0;
            for (int c = 0; c < 5 && !found; c++) begin
                if (out_valid) found = 1'b1;
                else begin @(posedge clk); #1; end
            end
            tests_run++;
            if (!found) begin tests_failed++; $display("FAIL mode%0d_timeout got no out_valid want 1", i); end
            tests_run++;
            if (z !== ve[i]) begin tests_failed++; $display("FAIL mode%0d_z got %h want %h", i, z, ve[i]); end
            tests_run++;
            if (out_parity !== (PAR_EN & (^ve[i]))) begin
                tests_failed++; $display("FAIL mode%0d_parity got %b want %b", i, out_parity, PAR_EN & (^ve[i]));
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        bit acc, xfer;
        logic [7:0] zs;
        int idx_in = 0, idx_out = 0, stalls = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (idx_in < 5) begin drive_vec(idx_in); in_valid = 1'b1; end
            else in_valid = 1'b0;
            cycle(acc, xfer, zs);
            if (in_valid && !acc) stalls++;
            if (acc) idx_in++;
            if (xfer) begin
                tests_run++;
                if (idx_out >= 5) begin tests_failed++; $display("FAIL b2b_extra got beat %0d want none", idx_out); end
                else if (zs !== ve[idx_out]) begin
                    tests_failed++; $display("FAIL b2b_z%0d got %h want %h", idx_out, zs, ve[idx_out]);
                end
                idx_out++;
            end
        end
        in_valid = 1'b0;
        tests_run++;
        if (idx_out !== 5) begin tests_failed++; $display("FAIL b2b_count got %0d want 5", idx_out); end
        tests_run++;
        if (stalls !== 0) begin tests_failed++; $display("FAIL b2b_stalls got %0d want 0", stalls); end
    endtask

    task automatic test_backpressure();
        bit acc, xfer;
        logic [7:0] zs, zhold;
        int idx_in = 0, idx_out = 0;
        logic [7:0] be [4];
        do_reset();
        set_vec(0, 2'b00, 8'hF0, 8'hCC, 8'h01, 8'h02, 8'h3C);
        set_vec(1, 2'b10, 8'hF0, 8'hCC, 8'h01, 8'h02, 8'hC3);
        set_vec(2, 2'b00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00);
        set_vec(3, 2'b10, 8'h0F, 8'h03, 8'h40, 8'h00, 8'h43);
        be[0] = 8'h3C; be[1] = 8'hC3; be[2] = 8'h00; be[3] = 8'h43;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (idx_in < 4) begin drive_vec(idx_in); in_valid = 1'b1; end
            cycle(acc, xfer, zs);
            if (acc) idx_in++;
        end
        #1;
        tests_run++;
        if (idx_in !== 2) begin tests_failed++; $display("FAIL bp_accepted got %0d want 2", idx_in); end
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        tests_run++;
        if (z !== 8'h3C || out_valid !== 1'b1) begin
            tests_failed++; $display("FAIL bp_head got z=%h v=%b want z=3c v=1", z, out_valid);
        end
        zhold = z;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (z !== zhold) begin tests_failed++; $display("FAIL bp_z_stable got %h want %h", z, zhold); end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && idx_out < 4; c++) begin
            if (idx_in < 4) begin drive_vec(idx_in); in_valid = 1'b1; end
            else in_valid = 1'b0;
            cycle(acc, xfer, zs);
            if (acc) idx_in++;
            if (xfer) begin
                tests_run++;
                if (zs !== be[idx_out]) begin
                    tests_failed++; $display("FAIL bp_order%0d got %h want %h", idx_out, zs, be[idx_out]);
                end
                idx_out++;
            end
        end
        in_valid = 1'b0;
        tests_run++;
        if (idx_out !== 4) begin tests_failed++; $display("FAIL bp_delivered got %0d want 4", idx_out); end
        tests_run++;
        if (out_count !== 16'd4) begin tests_failed++; $display("FAIL bp_count got %0d want 4", out_count); end
    endtask

    task automatic test_reset_midstream();
        bit seen = 1'b0;
        out_ready = 1'b0;
        mode = 2'b10; a0 = 8'h0F; a1 = 8'h03; b0 = 8'h40; c0 = 8'h00;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        nreset = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_count !== 16'd0) begin
            tests_failed++; $display("FAIL mid_reset got v=%b cnt=%0d want v=0 cnt=0", out_valid, out_count);
        end
        nreset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0 || out_count !== 16'd0) begin
            tests_failed++; $display("FAIL mid_discard got seen=%b cnt=%0d want seen=0 cnt=0", seen, out_count);
        end
    endtask

    task automatic test_wrap();
        bit acc, xfer, hit_ffff = 1'b0, hit_zero = 1'b0;
        logic [7:0] zs;
        int xfers = 0;
        do_reset();
        mode = 2'b00; a0 = 8'hF0; a1 = 8'hCC; b0 = 8'h01; c0 = 8'h02;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 70000 && !hit_zero; c++) begin
            cycle(acc, xfer, zs);
            if (xfer) begin
                xfers++;
                if (xfers == 65535) begin
                    hit_ffff = 1'b1;
                    tests_run++;
                    if (out_count !== 16'hFFFF) begin tests_failed++; $display("FAIL wrap_ffff got %h want ffff", out_count); end
                end
                if (xfers == 65536) begin
                    hit_zero = 1'b1;
                    tests_run++;
                    if (out_count !== 16'h0000) begin tests_failed++; $display("FAIL wrap_zero got %h want 0000", out_count); end
                end
            end
        end
        in_valid = 1'b0;
        tests_run++;
        if (!hit_ffff || !hit_zero) begin
            tests_failed++; $display("FAIL wrap_timeout got %0d transfers want 65536", xfers);
        end
    endtask

    initial begin
        nreset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        mode = 2'b00; a0 = '0; a1 = '0; b0 = '0; c0 = '0;
        test_reset();
        test_latency();
        test_modes();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
